lfsr_seq_ctrl: RTL and testbench

//   Seedable Fibonacci LFSR sequence generator with a valid/ready output stream.

---
 rtl/lfsr_seq_ctrl_pkg.sv | 22 ++
 rtl/lfsr_seq_ctrl_shift_reg.sv | 29 ++
 rtl/lfsr_seq_ctrl.sv | 84 ++++++++
 tb/tb_lfsr_seq_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/lfsr_seq_ctrl_pkg.sv
// lfsr_seq_ctrl_pkg: shared FSM state codes and default feedback masks for the LFSR sequencer
package lfsr_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  // Maximal-length feedback masks for widths 3..8; other widths fall back to the 4-bit mask.
  function automatic logic [15:0] default_taps(input int w);
    case (w)
      3:       return 16'b110;
      5:       return 16'b10100;
      6:       return 16'b110000;
      7:       return 16'b1100000;
      8:       return 16'b10111000;
      default: return 16'b1100;
    endcase
  endfunction

endpackage

// File: rtl/lfsr_seq_ctrl_shift_reg.sv
// lfsr_shift_reg: Fibonacci LFSR state register with load, shift and combinational next state
module lfsr_shift_reg
  import lfsr_seq_ctrl_pkg::*;
#(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH))
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic             shift_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] nxt_o
);

  logic [WIDTH-1:0] q_q;

  assign nxt_o = {q_q[WIDTH-2:0], ^(q_q & TAPS)};
  assign q_o   = q_q;

  // Load wins over shift so a rewind or reseed is never lost to a concurrent step.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) q_q <= '0;
    else if (load_i) q_q <= seed_i;
    else if (shift_i) q_q <= nxt_o;
  end

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// lfsr_seq_ctrl: seedable LFSR stream with valid/ready output and period measurement
module lfsr_seq_ctrl
  import lfsr_seq_ctrl_pkg::*;
#(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH)),
  parameter int               CNT_W = WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             seed_valid_i,
  input  logic [WIDTH-1:0] seed_i,
  output logic             seed_ready_o,
  input  logic             start_i,
  input  logic             stop_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_bit_o,
  output logic             period_done_o,
  output logic [CNT_W-1:0] period_len_o,
  output logic             seed_err_o
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] seed_q, seed_d, lfsr, lfsr_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d, len_q, len_d;
  logic             err_q, err_d;
  logic             seed_acc, seed_good, xfer, wrap, stop_run;

  assign seed_ready_o  = state_q != S_RUN;
  assign out_valid_o   = state_q == S_RUN;
  assign out_data_o    = lfsr;
  assign out_bit_o     = lfsr[WIDTH-1];
  assign period_done_o = wrap;
  assign period_len_o  = len_q;
  assign seed_err_o    = err_q;

  assign seed_acc  = seed_valid_i && seed_ready_o;
  assign seed_good = seed_acc && |seed_i;
  assign xfer      = out_valid_o && out_ready_i;
  assign wrap      = xfer && lfsr_nxt == seed_q;
  assign stop_run  = out_valid_o && stop_i;

  // A stop rewinds to the stored seed; otherwise a good seed loads the register.
  lfsr_shift_reg #(.WIDTH(WIDTH), .TAPS(TAPS)) u_sr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (seed_good || stop_run),
    .seed_i  (stop_run ? seed_q : seed_i),
    .shift_i (xfer),
    .q_o     (lfsr),
    .nxt_o   (lfsr_nxt)
  );

  // Next-state for the FSM, seed, step counter, period length and sticky seed error.
  always_comb begin
    state_d = state_q == S_IDLE  ? (seed_good ? S_ARMED : S_IDLE) :
              state_q == S_ARMED ? (start_i ? S_RUN : S_ARMED) :
                                   (stop_i ? S_ARMED : S_RUN);
    seed_d  = seed_good ? seed_i : seed_q;
    err_d   = seed_acc ? ~|seed_i : err_q;
    cnt_d   = stop_run || wrap ? '0 : xfer ? cnt_q + 1'b1 : cnt_q;
    len_d   = wrap ? cnt_q + 1'b1 : len_q;
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      seed_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// tb_lfsr_seq_ctrl: scoreboard bench for lfsr_seq_ctrl against a sequence-level reference model
module tb_lfsr_seq_ctrl;

  localparam logic [3:0] TAPS = 4'b1100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       seed_valid = 1'b0;
  logic [3:0] seed = '0;
  logic       seed_ready;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_data;
  logic       out_bit;
  logic       period_done;
  logic [3:0] period_len;
  logic       seed_err;

  lfsr_seq_ctrl #(.WIDTH(4), .TAPS(TAPS), .CNT_W(4)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .seed_valid_i  (seed_valid),
    .seed_i        (seed),
    .seed_ready_o  (seed_ready),
    .start_i       (start),
    .stop_i        (stop),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_data_o    (out_data),
    .out_bit_o     (out_bit),
    .period_done_o (period_done),
    .period_len_o  (period_len),
    .seed_err_o    (seed_err)
  );

  always #5 clk = ~clk;

  typedef struct { bit v; bit sr; bit err; } stat_t;
  typedef struct { logic [3:0] d; bit done; logic [3:0] len; } xfer_t;

  stat_t sq[$];
  xfer_t tq[$];
  int    total = 0;
  int    bad = 0;
  bit    chk_en = 1'b0;

  // Reference model: mode 0 idle, 1 armed, 2 streaming.
  int         m_mode;
  logic [3:0] m_seed, m_cur, m_len;
  int         m_since;
  bit         m_err;

  function automatic void chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [3:0] step(input logic [3:0] s);
    int p;
    p = $countones(s & TAPS) % 2;
    return 4'((int'(s) * 2 + p) % 16);
  endfunction

  function automatic void m_reset();
    m_mode = 0; m_seed = 0; m_cur = 0; m_len = 0; m_since = 0; m_err = 0;
  endfunction

  task automatic cyc(input bit r, input bit sv, input logic [3:0] sd,
                     input bit st, input bit sp, input bit rd);
    logic [3:0] n;
    int         old;
    rst_n = r; seed_valid = sv; seed = sd; start = st; stop = sp; out_ready = rd;
    sq.push_back('{m_mode == 2, m_mode != 2, m_err});
    if (m_mode == 2 && rd) tq.push_back('{m_cur, step(m_cur) == m_seed, m_len});
    old = m_mode;
    if (!r) m_reset();
    else if (old != 2) begin
      if (sv && sd == 0) m_err = 1;
      else if (sv) begin
        m_err = 0; m_seed = sd; m_cur = sd;
        if (old == 0) m_mode = 1;
      end
      if (old == 1 && st) m_mode = 2;
    end else begin
      if (rd) begin
        n = step(m_cur);
        m_since++;
        if (n == m_seed) begin
          m_len = 4'(m_since % 16);
          m_since = 0;
        end
        m_cur = n;
      end
      if (sp) begin
        m_mode = 1; m_cur = m_seed; m_since = 0;
      end
    end
    @(posedge clk); #1;
  endtask

  // Monitor: compare per-cycle status and every observed transfer against the queues.
  always @(negedge clk) begin
    if (chk_en) begin
      if (sq.size() > 0) begin
        stat_t s;
        s = sq.pop_front();
        chk("out_valid", int'(out_valid), int'(s.v));
        chk("seed_ready", int'(seed_ready), int'(s.sr));
        chk("seed_err", int'(seed_err), int'(s.err));
      end
      if (out_valid && out_ready) begin
        if (tq.size() == 0) begin
          chk("unexpected_xfer", 1, 0);
        end else begin
          xfer_t t;
          t = tq.pop_front();
          chk("out_data", int'(out_data), int'(t.d));
          chk("out_bit", int'(out_bit), int'(t.d[3]));
          chk("period_done", int'(period_done), int'(t.done));
          chk("period_len", int'(period_len), int'(t.len));
        end
      end else if (period_done) begin
        chk("stray_period_done", 1, 0);
      end
    end
  end

  initial begin
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    cyc(0, 0, 0, 0, 0, 0);
    chk("reset_plen", int'(period_len), 0);
    chk("reset_data", int'(out_data), 0);
    // Full period from seed 0001.
    cyc(1, 1, 4'd1, 0, 0, 1);
    cyc(1, 0, 0, 1, 0, 1);
    chk("first_word", int'(out_data), 1);
    repeat (15) cyc(1, 0, 0, 0, 0, 1);
    chk("period15", int'(period_len), 15);
    chk("wrapped_data", int'(out_data), 1);
    cyc(1, 0, 0, 0, 1, 0);
    // Stall pattern 1,0,0,1.
    cyc(1, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0);
    chk("stall_hold", int'(out_data), 2);
    cyc(1, 0, 0, 0, 0, 0);
    chk("stall_hold2", int'(out_data), 2);
    cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1, 1);
    // Zero seed in IDLE, start ignored, then good seed.
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 1, 4'd0, 0, 0, 1);
    cyc(1, 0, 0, 1, 0, 1);
    chk("idle_no_valid", int'(out_valid), 0);
    cyc(1, 1, 4'd3, 0, 0, 1);
    cyc(1, 0, 0, 1, 0, 1);
    chk("seed3_first", int'(out_data), 3);
    // Stop after 5 transfers, restart from seed 0001 for a full period.
    cyc(1, 0, 0, 0, 1, 0);
    cyc(1, 1, 4'd1, 1, 0, 1);
    repeat (5) cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 0, 1);
    chk("restart_data", int'(out_data), 1);
    repeat (3) cyc(1, 1, 4'd7, 0, 0, 1);
    repeat (12) cyc(1, 0, 0, 0, 0, 1);
    chk("restart_plen", int'(period_len), 15);
    // Reset mid-stream.
    repeat (4) cyc(1, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_plen", int'(period_len), 0);
    chk("rst_ready", int'(seed_ready), 1);
    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      logic [3:0] sd;
      sd = ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      cyc($urandom_range(0, 299) != 0, $urandom_range(0, 7) == 0, sd,
          $urandom_range(0, 5) == 0, $urandom_range(0, 59) == 0,
          $urandom_range(0, 3) != 0);
    end
    cyc(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("queues_drained", sq.size() + tq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
